calc_op_sequencer: RTL

Control sequencer for the calculator arithmetic datapath. It accepts one operation per start pulse and latches the operands. Add and subtract complete in one execute cycle; multiply (shift-add) and divide (restoring) run iteratively in the same block. The result is reported with a one-cycle done pulse. Sits between the calculator top-level control (start/done handshake) and the display/LED logic that consumes result and flags.

---
 rtl/calc_pkg.sv | 18 +
 rtl/calc_div_step.sv | 20 ++
 rtl/calc_op_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared opcode and FSM state encodings for the calculator op sequencer.
// No logic lives here. Consumers have no latency or backpressure dependency on it.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/calc_div_step.sv
// One restoring-division step: shift in the next dividend bit, then subtract the divisor if it fits.
// Purely combinational (0 cycles) with no backpressure. The caller keeps rem_in < divisor.
module calc_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] diff;

    // Because rem_in < divisor, the trial value is below 2*divisor, so bit WIDTH of diff is exactly the borrow.
    assign diff    = {rem_in, bit_in} - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : {rem_in[WIDTH-2:0], bit_in};

endmodule

// File: rtl/calc_op_sequencer.sv
// Start/done sequencer: ADD/SUB finish in 1 EXEC cycle, MUL (shift-add) and DIV (restoring) in WIDTH cycles (CALC_SEQ_MUL_EARLY_TERM_EN shortens MUL).
// A start seen while busy is dropped with no queuing. done is a one-cycle pulse, and the results hold until the next accepted start.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           opcode,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 overflow,
    output logic                 div_zero
);

    state_t               state, state_nxt;
    opcode_t              opc;
    logic [2*WIDTH-1:0]   sh_a;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     sh_b;
    logic [WIDTH-1:0]     prem;
    logic [WIDTH-1:0]     prem_nxt;
    logic [WIDTH-1:0]     quo;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic                 q_bit;
    logic                 mul_last;
    logic                 div_last;
    logic                 exec_last;

    // sh_a shifts left every MUL/DIV cycle. The MUL adds the multiplicand from it, and the DIV takes the next dividend bit from bit WIDTH-1.
    assign sum      = {1'b0, sh_a[WIDTH-1:0]} + {1'b0, b_q};
    assign diff     = {1'b0, sh_a[WIDTH-1:0]} - {1'b0, b_q};
    assign acc_nxt  = sh_b[0] ? (acc + sh_a) : acc;
    assign div_last = (cnt == CNT_W'(WIDTH - 1));

`ifdef CALC_SEQ_MUL_EARLY_TERM_EN
    assign mul_last = (sh_b[WIDTH-1:1] == '0);
`else
    assign mul_last = (cnt == CNT_W'(WIDTH - 1));
`endif

    calc_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (prem),
        .divisor (b_q),
        .bit_in  (sh_a[WIDTH-1]),
        .rem_out (prem_nxt),
        .q_bit   (q_bit)
    );

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        exec_last = 1'b1;
        case (opc)
            OP_MUL:  exec_last = mul_last;
            OP_DIV:  exec_last = (b_q == '0) || div_last;
            default: exec_last = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_EXEC;
            ST_EXEC: if (exec_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opc       <= OP_ADD;
            sh_a      <= '0;
            acc       <= '0;
            b_q       <= '0;
            sh_b      <= '0;
            prem      <= '0;
            quo       <= '0;
            cnt       <= '0;
            result    <= '0;
            remainder <= '0;
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opc       <= opcode_t'(opcode);
                        sh_a      <= {{WIDTH{1'b0}}, op_a};
                        b_q       <= op_b;
                        sh_b      <= op_b;
                        acc       <= '0;
                        prem      <= '0;
                        quo       <= '0;
                        cnt       <= '0;
                        result    <= '0;
                        remainder <= '0;
                        overflow  <= 1'b0;
                        div_zero  <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    cnt <= cnt + 1'b1;
                    case (opc)
                        OP_ADD: begin
                            result   <= {{(WIDTH-1){1'b0}}, sum};
                            overflow <= sum[WIDTH];
                        end
                        OP_SUB: begin
                            result   <= {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                            overflow <= diff[WIDTH];
                        end
                        OP_MUL: begin
                            acc  <= acc_nxt;
                            sh_a <= sh_a << 1;
                            sh_b <= sh_b >> 1;
                            if (mul_last) result <= acc_nxt;
                        end
                        default: begin
                            if (b_q == '0) begin
                                div_zero  <= 1'b1;
                                result    <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                                remainder <= sh_a[WIDTH-1:0];
                            end else begin
                                prem <= prem_nxt;
                                quo  <= {quo[WIDTH-2:0], q_bit};
                                sh_a <= sh_a << 1;
                                if (div_last) begin
                                    result    <= {{WIDTH{1'b0}}, quo[WIDTH-2:0], q_bit};
                                    remainder <= prem_nxt;
                                end
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
